// File: rtl/pipe_run_ctrl.sv
// Run/step/breakpoint controller and stall scheduler for the 5-stage pipeline.
// Merges per-stage stall requests with debug commands into one stall vector
// and keeps an active-cycle counter for the observer.
module pipe_run_ctrl #(
  parameter bit          RUN_ON_RESET = 1'b1,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STEP_W       = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              halt_i,
  input  logic              step_i,
  input  logic [STEP_W-1:0] step_cnt_i,
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              cnt_clr_i,
  output logic [5:0]        stall_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic              bp_hit_o,
  output logic [STEP_W-1:0] step_left_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t             state_q;
  logic [STEP_W-1:0]  step_left_q;
  logic               bp_skip_q;
  logic               bp_hit_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               active;
  logic               bp_match;
  logic               advance;
  logic               step_ok;

  // Breakpoint detection, stall vector merge and advance qualifier
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_STEP);
    bp_match = bp_en_i && (pc_i == bp_addr_i) && !bp_skip_q && active;
    step_ok  = step_i && (step_cnt_i != '0);
    if (rst || !active || bp_match) begin
      stall_o = 6'b111111;
    end else if (stallreq_ex_i) begin
      stall_o = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_o = 6'b000111;
    end else begin
      stall_o = 6'b000000;
    end
    advance = ~stall_o[0];
  end

  // Run-control FSM, step counter, breakpoint skip/hit flags and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN_ON_RESET ? S_RUN : S_HALT;
      step_left_q <= '0;
      bp_skip_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bp_hit_q <= bp_match && !halt_i;

      // Skip is only ever set from BREAK, where advance is 0, so a later set wins cleanly
      if (advance) begin
        bp_skip_q <= 1'b0;
      end

      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (active && (stall_o != 6'b111111)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (halt_i) begin
        state_q <= S_HALT;
        if (state_q == S_STEP) begin
          step_left_q <= '0;
        end
      end else if (bp_match) begin
        state_q <= S_BREAK;
      end else begin
        case (state_q)
          S_HALT: begin
            if (run_i) begin
              state_q <= S_RUN;
            end else if (step_ok) begin
              state_q     <= S_STEP;
              step_left_q <= step_cnt_i;
            end
          end
          S_RUN: begin
          end
          S_STEP: begin
            if (advance) begin
              step_left_q <= step_left_q - STEP_W'(1);
              if (step_left_q == STEP_W'(1)) begin
                state_q <= S_HALT;
              end
            end
          end
          S_BREAK: begin
            if (run_i) begin
              state_q   <= S_RUN;
              bp_skip_q <= 1'b1;
            end else if (step_ok) begin
              state_q     <= S_STEP;
              step_left_q <= step_cnt_i;
              bp_skip_q   <= 1'b1;
            end
          end
          default: state_q <= S_HALT;
        endcase
      end
    end
  end

  assign state_o     = state_q;
  assign halted_o    = (state_q == S_HALT) || (state_q == S_BREAK);
  assign bp_hit_o    = bp_hit_q;
  assign step_left_o = step_left_q;
  assign cycle_cnt_o = cnt_q;

endmodule
